column_peak_finder: RTL and testbench

COLUMN_PEAK_FINDER -- requirements
Module: column_peak_finder

---
 rtl/column_peak_finder_pkg.sv | 17 +
 rtl/sample_mux.sv | 12 +
 rtl/column_peak_finder.sv | 95 +++++++++
 tb/tb_column_peak_finder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/column_peak_finder_pkg.sv
// Shared constants and state encoding for the column peak finder.
package column_peak_finder_pkg;

  localparam int unsigned N_SAMPLES = 32;
  localparam int unsigned SAMPLE_W  = 5;
  localparam int unsigned IDX_W     = $clog2(N_SAMPLES);
  // Wide enough for N_SAMPLES copies of the largest sample (992 -> 10 bits).
  localparam int unsigned SUM_W     = $clog2(N_SAMPLES * ((1 << SAMPLE_W) - 1) + 1);
  localparam int unsigned SAMPLES_W = N_SAMPLES * SAMPLE_W;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/sample_mux.sv
// Selects one SAMPLE_W-bit sample out of the packed snapshot vector.
module sample_mux
  import column_peak_finder_pkg::*;
(
  input  logic [SAMPLES_W-1:0] samples,
  input  logic [IDX_W-1:0]     sel,
  output logic [SAMPLE_W-1:0]  sample
);

  assign sample = samples[sel * SAMPLE_W +: SAMPLE_W];

endmodule

// File: rtl/column_peak_finder.sv
// Scans a snapshot of 32 column samples one per cycle, reporting the peak
// (lowest index on ties), the total sum and a threshold hit.
module column_peak_finder
  import column_peak_finder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SAMPLES_W-1:0] samples,
  input  logic [SAMPLE_W-1:0]  threshold,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     peak_idx,
  output logic [SAMPLE_W-1:0]  peak_val,
  output logic [SUM_W-1:0]     sum,
  output logic                 found
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q;
  logic [SAMPLES_W-1:0] snap_q;
  logic [SAMPLE_W-1:0]  thr_q;
  logic [SAMPLE_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SUM_W-1:0]     acc_q, acc_d;
  logic [SAMPLE_W-1:0]  cur;
  logic                 first, take, last;

  sample_mux u_sample_mux (
    .samples (snap_q),
    .sel     (cnt_q),
    .sample  (cur)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StScan;
      StScan:  if (cnt_q == IDX_W'(N_SAMPLES - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    first = (cnt_q == '0);
    take  = first || (cur > max_q);
    max_d = take ? cur : max_q;
    idx_d = take ? cnt_q : idx_q;
    acc_d = first ? SUM_W'(cur) : acc_q + SUM_W'(cur);
    last  = (state_q == StScan) && (cnt_q == IDX_W'(N_SAMPLES - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      snap_q   <= '0;
      thr_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      peak_idx <= '0;
      peak_val <= '0;
      sum      <= '0;
      found    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != StIdle);
      done    <= (state_d == StDone);
      if (state_q == StIdle && start) begin
        snap_q <= samples;
        thr_q  <= threshold;
        cnt_q  <= '0;
      end
      if (state_q == StScan) begin
        cnt_q <= cnt_q + 1'b1;
        max_q <= max_d;
        idx_q <= idx_d;
        acc_q <= acc_d;
      end
      // Results are published only once the final sample has been folded in.
      if (last) begin
        peak_idx <= idx_d;
        peak_val <= max_d;
        sum      <= acc_d;
        found    <= (max_d >= thr_q);
      end
    end
  end

endmodule

// File: tb/tb_column_peak_finder.sv
// Randomized self-checking bench for column_peak_finder against a
// behavioural peak/sum model.
module tb_column_peak_finder;
  import column_peak_finder_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [SAMPLES_W-1:0] samples;
  logic [SAMPLE_W-1:0]  threshold;
  logic                 busy, done, found;
  logic [IDX_W-1:0]     peak_idx;
  logic [SAMPLE_W-1:0]  peak_val;
  logic [SUM_W-1:0]     sum;

  int n_checks = 0;
  int n_fail   = 0;
  int last_idx = 0, last_val = 0, last_sum = 0, last_found = 0;

  column_peak_finder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .samples   (samples),
    .threshold (threshold),
    .busy      (busy),
    .done      (done),
    .peak_idx  (peak_idx),
    .peak_val  (peak_val),
    .sum       (sum),
    .found     (found)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Peak is the largest value; its index is the lowest position holding it.
  function automatic void ref_model(input logic [SAMPLES_W-1:0] s, input logic [4:0] thr,
                                    output int idx, output int val, output int tot,
                                    output int fnd);
    val = 0;
    tot = 0;
    for (int k = 0; k < 32; k++) begin
      tot += int'(s[k*5 +: 5]);
      if (int'(s[k*5 +: 5]) > val) val = int'(s[k*5 +: 5]);
    end
    idx = 0;
    for (int k = 31; k >= 0; k--) if (int'(s[k*5 +: 5]) == val) idx = k;
    fnd = (val >= int'(thr)) ? 1 : 0;
  endfunction

  function automatic logic [SAMPLES_W-1:0] rand_samples(input int maxv);
    logic [SAMPLES_W-1:0] s;
    for (int k = 0; k < 32; k++) s[k*5 +: 5] = 5'($urandom_range(0, maxv));
    return s;
  endfunction

  function automatic bit outputs_are(input int i, input int v, input int t, input int f);
    return (int'(peak_idx) == i) && (int'(peak_val) == v) && (int'(sum) == t) &&
           (int'(found) == f);
  endfunction

  task automatic run_scan(input string tag, input logic [SAMPLES_W-1:0] s,
                          input logic [4:0] thr, input bit disturb);
    int ei, ev, es, ef, lat, hold_bad, busy_bad, extra;
    ref_model(s, thr, ei, ev, es, ef);
    @(negedge clk);
    samples   = s;
    threshold = thr;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    lat = 0;
    hold_bad = 0;
    busy_bad = 0;
    while (lat < 40) begin
      if (disturb) begin
        start     = (lat == 9 || lat == 19);
        samples   = rand_samples(31);
        threshold = 5'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (!outputs_are(last_idx, last_val, last_sum, last_found)) hold_bad++;
      if (!busy) busy_bad++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, 32);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_busy_scan"}, busy_bad, 0);
    check({tag, "_peak_idx"}, peak_idx, ei);
    check({tag, "_peak_val"}, peak_val, ev);
    check({tag, "_sum"}, sum, es);
    check({tag, "_found"}, found, ef);
    last_idx = ei; last_val = ev; last_sum = es; last_found = ef;
    @(negedge clk);
    check({tag, "_done_pulse"}, {busy, done}, 0);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check({tag, "_no_requeue"}, extra, 0);
    end
  endtask

  initial begin
    logic [SAMPLES_W-1:0] s;
    int ei, ev, es, ef, mism, dones, lat;
    bit exp_done, exp_busy;

    rst = 1'b0;
    start = 1'b0;
    samples = '0;
    threshold = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, peak_idx, peak_val, sum, found}, 0);
    rst = 1'b1;

    run_scan("all_zero", '0, 5'd1, 1'b0);
    for (int k = 0; k < 32; k++) s[k*5 +: 5] = 5'(k);
    run_scan("ramp", s, 5'd31, 1'b0);
    for (int k = 0; k < 32; k++) s[k*5 +: 5] = 5'd3;
    s[5*5 +: 5] = 5'd17;
    s[20*5 +: 5] = 5'd17;
    run_scan("tie", s, 5'd10, 1'b0);
    run_scan("midscan_start", rand_samples(31), 5'($urandom), 1'b1);
    for (int r = 0; r < 6; r++) begin
      run_scan($sformatf("rand%0d", r), rand_samples((r % 2 == 0) ? 3 : 31),
               5'($urandom), 1'b0);
    end

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    samples = rand_samples(31);
    threshold = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_outputs", {busy, done, peak_idx, peak_val, sum, found}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);
    last_idx = 0; last_val = 0; last_sum = 0; last_found = 0;
    run_scan("after_abort", rand_samples(31), 5'($urandom), 1'b0);

    // start held high: back-to-back scans every 34 cycles.
    s = rand_samples(31);
    ref_model(s, 5'd16, ei, ev, es, ef);
    @(negedge clk);
    samples = s;
    threshold = 5'd16;
    start = 1'b1;
    mism = 0;
    dones = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_done = (i >= 33) && ((i - 33) % 34 == 0);
      exp_busy = !((i >= 34) && ((i - 34) % 34 == 0));
      if (done !== exp_done || busy !== exp_busy) mism++;
      if (done) begin
        dones++;
        if (!outputs_are(ei, ev, es, ef)) mism++;
      end
    end
    start = 1'b0;
    check("held_pattern", mism, 0);
    check("held_done_count", dones, 2);
    lat = 0;
    while (lat < 40 && !done) begin
      @(negedge clk);
      lat++;
    end
    check("held_drain_done", done, 1);
    check("held_drain_result", outputs_are(ei, ev, es, ef), 1);
    @(negedge clk);
    check("held_drain_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
